// File: rtl/branch_resolve_queue_pkg.sv
// Shared types and constants for the branch resolve queue that sits behind the gshare fetch predictor.
package brq_pkg;

    localparam int DEPTH = 8;
    localparam int TAG_W = 3;
    localparam int GHR_W = 5;
    localparam int PC_W  = 8;

    typedef struct packed {
        logic             valid;
        logic             resolved;
        logic [PC_W-1:0]  pc;
        logic [GHR_W-1:0] ghr;
        logic             pred;
        logic             taken;
    } brq_entry_t;

    // History as it should have been after this branch resolved with the given outcome.
    function automatic logic [GHR_W-1:0] next_ghr(input logic [GHR_W-1:0] ghr, input logic taken);
        return {ghr[GHR_W-2:0], taken};
    endfunction

endpackage

// File: rtl/branch_resolve_queue_if.sv
// Fetch-allocate, execute-resolve, flush and PHT-training signals of the branch resolve queue.
interface branch_resolve_queue_if;
    import brq_pkg::*;

    logic             alloc_valid1;
    logic             alloc_valid2;
    logic [PC_W-1:0]  alloc_pc1;
    logic [PC_W-1:0]  alloc_pc2;
    logic [GHR_W-1:0] alloc_ghr1;
    logic [GHR_W-1:0] alloc_ghr2;
    logic             alloc_pred1;
    logic             alloc_pred2;
    logic             alloc_ready;
    logic [TAG_W-1:0] alloc_tag1;
    logic [TAG_W-1:0] alloc_tag2;
    logic             res_valid;
    logic [TAG_W-1:0] res_tag;
    logic             res_taken;
    logic             mispredict;
    logic [TAG_W-1:0] mispredict_tag;
    logic [GHR_W-1:0] recover_ghr;
    logic             upd_valid;
    logic [PC_W-1:0]  upd_pc;
    logic [GHR_W-1:0] upd_ghr;
    logic             upd_taken;
    logic [TAG_W:0]   count;
    logic             empty;

    modport master (
        output alloc_valid1, alloc_valid2, alloc_pc1, alloc_pc2, alloc_ghr1, alloc_ghr2,
               alloc_pred1, alloc_pred2, res_valid, res_tag, res_taken,
        input  alloc_ready, alloc_tag1, alloc_tag2, mispredict, mispredict_tag, recover_ghr,
               upd_valid, upd_pc, upd_ghr, upd_taken, count, empty
    );

    modport slave (
        input  alloc_valid1, alloc_valid2, alloc_pc1, alloc_pc2, alloc_ghr1, alloc_ghr2,
               alloc_pred1, alloc_pred2, res_valid, res_tag, res_taken,
        output alloc_ready, alloc_tag1, alloc_tag2, mispredict, mispredict_tag, recover_ghr,
               upd_valid, upd_pc, upd_ghr, upd_taken, count, empty
    );

endinterface

// File: rtl/branch_resolve_queue_ptr.sv
// Head/tail pointers with a wrap bit, plus occupancy, empty and allocate-ready derived from them.
module brq_ptr
    import brq_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             head_inc,
    input  logic [1:0]       alloc_n,
    input  logic             flush,
    input  logic [TAG_W-1:0] flush_tag,
    output logic [TAG_W-1:0] head_idx,
    output logic [TAG_W-1:0] tail_idx,
    output logic [TAG_W:0]   count,
    output logic             empty,
    output logic             alloc_ready
);

    logic [TAG_W:0]   head_r;
    logic [TAG_W:0]   tail_r;
    logic [TAG_W:0]   head_nxt_s;
    logic [TAG_W:0]   tail_nxt_s;
    logic [TAG_W:0]   count_s;
    logic [TAG_W-1:0] flush_rel_s;
    logic             full_s;

    // Next pointers; a flush rewinds tail to one past the mispredicted entry, measured from head.
    always_comb begin
        flush_rel_s = flush_tag - head_r[TAG_W-1:0];
        if (head_inc) begin
            head_nxt_s = head_r + {{TAG_W{1'b0}}, 1'b1};
        end else begin
            head_nxt_s = head_r;
        end
        if (flush) begin
            tail_nxt_s = head_r + {1'b0, flush_rel_s} + {{TAG_W{1'b0}}, 1'b1};
        end else begin
            tail_nxt_s = tail_r + {{(TAG_W-1){1'b0}}, alloc_n};
        end
    end

    // Pointer registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_r <= {(TAG_W+1){1'b0}};
            tail_r <= {(TAG_W+1){1'b0}};
        end else begin
            head_r <= head_nxt_s;
            tail_r <= tail_nxt_s;
        end
    end

    // Occupancy flags; full differs from empty only in the wrap bit.
    always_comb begin
        count_s     = tail_r - head_r;
        full_s      = (head_r[TAG_W-1:0] == tail_r[TAG_W-1:0]) && (head_r[TAG_W] != tail_r[TAG_W]);
        empty       = (head_r == tail_r);
        alloc_ready = !full_s && (count_s != (TAG_W+1)'(DEPTH - 1));
        count       = count_s;
        head_idx    = head_r[TAG_W-1:0];
        tail_idx    = tail_r[TAG_W-1:0];
    end

endmodule

// File: rtl/branch_resolve_queue.sv
// Branch resolve queue: records predicted branches, flags mispredicts, retires in order to train the PHT.
// Optional BRQ_STATS_EN adds saturating retired-branch and mispredict counters.
module branch_resolve_queue
    import brq_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    branch_resolve_queue_if.slave bus
`ifdef BRQ_STATS_EN
    ,
    output logic [15:0]           stat_branches,
    output logic [15:0]           stat_mispredicts
`endif
);

    brq_entry_t       entries_r [DEPTH];
    logic [TAG_W-1:0] head_idx_s;
    logic [TAG_W-1:0] tail_idx_s;
    logic [TAG_W-1:0] tag1_s;
    logic [TAG_W-1:0] tag2_s;
    logic [TAG_W-1:0] res_rel_s;
    logic             res_ok_s;
    logic             flush_s;
    logic             retire_s;
    logic             alloc_ok_s;
    logic             wr1_s;
    logic             wr2_s;
    logic [1:0]       alloc_n_s;

    logic             mispredict_r;
    logic [TAG_W-1:0] mp_tag_r;
    logic [GHR_W-1:0] recover_r;
    logic             upd_valid_r;
    logic [PC_W-1:0]  upd_pc_r;
    logic [GHR_W-1:0] upd_ghr_r;
    logic             upd_taken_r;

    brq_ptr u_ptr (
        .clk         (clk),
        .rst         (rst),
        .head_inc    (retire_s),
        .alloc_n     (alloc_n_s),
        .flush       (flush_s),
        .flush_tag   (bus.res_tag),
        .head_idx    (head_idx_s),
        .tail_idx    (tail_idx_s),
        .count       (bus.count),
        .empty       (bus.empty),
        .alloc_ready (bus.alloc_ready)
    );

    // Resolve/retire qualification; wrong-path allocations are dropped in a mispredict cycle.
    always_comb begin
        res_ok_s   = bus.res_valid && entries_r[bus.res_tag].valid && !entries_r[bus.res_tag].resolved;
        flush_s    = res_ok_s && (bus.res_taken != entries_r[bus.res_tag].pred);
        retire_s   = entries_r[head_idx_s].valid && entries_r[head_idx_s].resolved;
        alloc_ok_s = bus.alloc_ready && !flush_s;
        wr1_s      = alloc_ok_s && bus.alloc_valid1;
        wr2_s      = alloc_ok_s && bus.alloc_valid2;
        alloc_n_s  = {1'b0, wr1_s} + {1'b0, wr2_s};
        tag1_s     = tail_idx_s;
        if (bus.alloc_valid1) begin
            tag2_s = tail_idx_s + {{(TAG_W-1){1'b0}}, 1'b1};
        end else begin
            tag2_s = tail_idx_s;
        end
        res_rel_s  = bus.res_tag - head_idx_s;
    end

    // Entry storage: younger-than-mispredict invalidation, retire clear, resolve and allocate writes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (flush_s && ((TAG_W'(i) - head_idx_s) > res_rel_s)) begin
                    entries_r[i].valid <= 1'b0;
                end
            end
            if (retire_s) begin
                entries_r[head_idx_s].valid    <= 1'b0;
                entries_r[head_idx_s].resolved <= 1'b0;
            end
            if (res_ok_s) begin
                entries_r[bus.res_tag].resolved <= 1'b1;
                entries_r[bus.res_tag].taken    <= bus.res_taken;
            end
            if (wr1_s) begin
                entries_r[tag1_s] <= '{valid: 1'b1, resolved: 1'b0, pc: bus.alloc_pc1,
                                       ghr: bus.alloc_ghr1, pred: bus.alloc_pred1, taken: 1'b0};
            end
            if (wr2_s) begin
                entries_r[tag2_s] <= '{valid: 1'b1, resolved: 1'b0, pc: bus.alloc_pc2,
                                       ghr: bus.alloc_ghr2, pred: bus.alloc_pred2, taken: 1'b0};
            end
        end
    end

    // Registered flush pulse and PHT training strobe; payloads hold between pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mispredict_r <= 1'b0;
            mp_tag_r     <= {TAG_W{1'b0}};
            recover_r    <= {GHR_W{1'b0}};
            upd_valid_r  <= 1'b0;
            upd_pc_r     <= {PC_W{1'b0}};
            upd_ghr_r    <= {GHR_W{1'b0}};
            upd_taken_r  <= 1'b0;
        end else begin
            mispredict_r <= flush_s;
            if (flush_s) begin
                mp_tag_r  <= bus.res_tag;
                recover_r <= next_ghr(entries_r[bus.res_tag].ghr, bus.res_taken);
            end
            upd_valid_r <= retire_s;
            if (retire_s) begin
                upd_pc_r    <= entries_r[head_idx_s].pc;
                upd_ghr_r   <= entries_r[head_idx_s].ghr;
                upd_taken_r <= entries_r[head_idx_s].taken;
            end
        end
    end

    assign bus.alloc_tag1     = tag1_s;
    assign bus.alloc_tag2     = tag2_s;
    assign bus.mispredict     = mispredict_r;
    assign bus.mispredict_tag = mp_tag_r;
    assign bus.recover_ghr    = recover_r;
    assign bus.upd_valid      = upd_valid_r;
    assign bus.upd_pc         = upd_pc_r;
    assign bus.upd_ghr        = upd_ghr_r;
    assign bus.upd_taken      = upd_taken_r;

`ifdef BRQ_STATS_EN
    logic [15:0] stat_br_r;
    logic [15:0] stat_mp_r;

    // Saturating event counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_br_r <= 16'h0000;
            stat_mp_r <= 16'h0000;
        end else begin
            if (upd_valid_r && (stat_br_r != 16'hFFFF)) begin
                stat_br_r <= stat_br_r + 16'h0001;
            end
            if (mispredict_r && (stat_mp_r != 16'hFFFF)) begin
                stat_mp_r <= stat_mp_r + 16'h0001;
            end
        end
    end

    assign stat_branches    = stat_br_r;
    assign stat_mispredicts = stat_mp_r;
`endif

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Randomized and directed bench for branch_resolve_queue against an in-order list model with a timed scoreboard.
module tb_branch_resolve_queue;
    import brq_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    int   next_tag = 0;

    typedef struct { int tag; logic [7:0] pc; logic [4:0] ghr; bit pred; bit resolved; bit taken; } br_t;
    typedef struct { int cyc; logic [7:0] pc; logic [4:0] ghr; bit taken; } upd_t;
    typedef struct { int cyc; int tag; logic [4:0] rec; } mp_t;

    br_t  mq[$];
    upd_t upd_q[$];
    mp_t  mp_q[$];

    branch_resolve_queue_if bus();

    branch_resolve_queue dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        else n_pass++;
    endtask

    // Scoreboard monitor: every cycle the pulses must match exactly what the model scheduled for it.
    always @(negedge clk) begin
        upd_t u;
        mp_t  m;
        bit   exp_u;
        bit   exp_m;
        if (rst) begin
            exp_u = (upd_q.size() > 0) && (upd_q[0].cyc <= cyc);
            exp_m = (mp_q.size() > 0) && (mp_q[0].cyc <= cyc);
            chk("upd_valid", 32'(bus.upd_valid), 32'(exp_u));
            chk("mispredict", 32'(bus.mispredict), 32'(exp_m));
            if (exp_u) begin
                u = upd_q.pop_front();
                if (bus.upd_valid === 1'b1) begin
                    chk("upd_pc", 32'(bus.upd_pc), 32'(u.pc));
                    chk("upd_ghr", 32'(bus.upd_ghr), 32'(u.ghr));
                    chk("upd_taken", 32'(bus.upd_taken), 32'(u.taken));
                end
            end
            if (exp_m) begin
                m = mp_q.pop_front();
                if (bus.mispredict === 1'b1) begin
                    chk("mispredict_tag", 32'(bus.mispredict_tag), 32'(m.tag));
                    chk("recover_ghr", 32'(bus.recover_ghr), 32'(m.rec));
                end
            end
        end
    end

    // Reference: an ordered list of in-flight branches; one call is one clock cycle.
    task automatic model_step(input bit v1, input bit v2, input logic [7:0] pc1, input logic [7:0] pc2,
                              input logic [4:0] g1, input logic [4:0] g2, input bit p1, input bit p2,
                              input bit rv, input int rt, input bit rtk);
        int   sz0 = mq.size();
        bit   flush = 1'b0;
        upd_t u;
        mp_t  m;
        br_t  b;
        if (sz0 > 0 && mq[0].resolved) begin
            u.cyc = cyc + 1; u.pc = mq[0].pc; u.ghr = mq[0].ghr; u.taken = mq[0].taken;
            upd_q.push_back(u);
            void'(mq.pop_front());
        end
        if (rv) begin
            for (int i = 0; i < mq.size(); i++) begin
                if (mq[i].tag == rt) begin
                    if (!mq[i].resolved) begin
                        mq[i].resolved = 1'b1;
                        mq[i].taken = rtk;
                        if (rtk != mq[i].pred) begin
                            flush = 1'b1;
                            m.cyc = cyc + 1; m.tag = rt; m.rec = {mq[i].ghr[3:0], rtk};
                            mp_q.push_back(m);
                            while (mq.size() > i + 1) void'(mq.pop_back());
                            next_tag = (rt + 1) % DEPTH;
                        end
                    end
                    break;
                end
            end
        end
        if (sz0 <= DEPTH - 2 && !flush) begin
            if (v1) begin
                b.tag = next_tag; b.pc = pc1; b.ghr = g1; b.pred = p1; b.resolved = 1'b0; b.taken = 1'b0;
                mq.push_back(b); next_tag = (next_tag + 1) % DEPTH;
            end
            if (v2) begin
                b.tag = next_tag; b.pc = pc2; b.ghr = g2; b.pred = p2; b.resolved = 1'b0; b.taken = 1'b0;
                mq.push_back(b); next_tag = (next_tag + 1) % DEPTH;
            end
        end
    endtask

    task automatic drive(input bit v1, input bit v2, input logic [7:0] pc1, input logic [7:0] pc2,
                         input logic [4:0] g1, input logic [4:0] g2, input bit p1, input bit p2,
                         input bit rv, input int rt, input bit rtk);
        bus.alloc_valid1 = v1;  bus.alloc_valid2 = v2;
        bus.alloc_pc1    = pc1; bus.alloc_pc2    = pc2;
        bus.alloc_ghr1   = g1;  bus.alloc_ghr2   = g2;
        bus.alloc_pred1  = p1;  bus.alloc_pred2  = p2;
        bus.res_valid    = rv;  bus.res_tag      = 3'(rt); bus.res_taken = rtk;
    endtask

    // One cycle: drive after negedge, check combinational outputs, advance model, check occupancy.
    task automatic step(input bit v1, input bit v2, input logic [7:0] pc1, input logic [7:0] pc2,
                        input logic [4:0] g1, input logic [4:0] g2, input bit p1, input bit p2,
                        input bit rv, input int rt, input bit rtk);
        drive(v1, v2, pc1, pc2, g1, g2, p1, p2, rv, rt, rtk);
        #1;
        chk("alloc_ready", 32'(bus.alloc_ready), 32'(mq.size() <= DEPTH - 2));
        if (v1) chk("alloc_tag1", 32'(bus.alloc_tag1), 32'(next_tag));
        if (v2) chk("alloc_tag2", 32'(bus.alloc_tag2), 32'(v1 ? (next_tag + 1) % DEPTH : next_tag));
        model_step(v1, v2, pc1, pc2, g1, g2, p1, p2, rv, rt, rtk);
        @(posedge clk);
        #1;
        chk("count", 32'(bus.count), 32'(mq.size()));
        chk("empty", 32'(bus.empty), 32'(mq.size() == 0));
        @(negedge clk);
    endtask

    task automatic idle();
        step(0, 0, 8'h00, 8'h00, 5'h00, 5'h00, 0, 0, 0, 0, 0);
    endtask

    task automatic resolve(input int rt, input bit tk);
        step(0, 0, 8'h00, 8'h00, 5'h00, 5'h00, 0, 0, 1, rt, tk);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_count"}, 32'(bus.count), 32'd0);
        chk({tag, "_empty"}, 32'(bus.empty), 32'd1);
        chk({tag, "_alloc_ready"}, 32'(bus.alloc_ready), 32'd1);
        chk({tag, "_mispredict"}, 32'(bus.mispredict), 32'd0);
        chk({tag, "_mispredict_tag"}, 32'(bus.mispredict_tag), 32'd0);
        chk({tag, "_recover_ghr"}, 32'(bus.recover_ghr), 32'd0);
        chk({tag, "_upd_valid"}, 32'(bus.upd_valid), 32'd0);
        chk({tag, "_upd_pc"}, 32'(bus.upd_pc), 32'd0);
        chk({tag, "_upd_ghr"}, 32'(bus.upd_ghr), 32'd0);
        chk({tag, "_upd_taken"}, 32'(bus.upd_taken), 32'd0);
    endtask

    task automatic clear_model();
        mq.delete(); upd_q.delete(); mp_q.delete(); next_tag = 0;
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b0;
        #1;
        chk_reset_outs(tag);
        clear_model();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic drain();
        for (int k = 0; k < 40 && (mq.size() > 0 || upd_q.size() > 0); k++) begin
            int idx = -1;
            for (int i = 0; i < mq.size(); i++) begin
                if (!mq[i].resolved) begin idx = i; break; end
            end
            if (idx >= 0) resolve(mq[idx].tag, mq[idx].pred);
            else idle();
        end
    endtask

    initial begin
        drive(0, 0, 8'h00, 8'h00, 5'h00, 5'h00, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        chk_reset_outs("reset");
        rst = 1'b1;

        // Two-wide allocate, out-of-order correct resolves, in-order training.
        step(1, 1, 8'h10, 8'h14, 5'h03, 5'h07, 1, 0, 0, 0, 0);
        resolve(1, 0);
        resolve(0, 1);
        idle(); idle(); idle();

        // Mispredict on tag 1 with younger entries behind it.
        do_reset("reset2");
        step(1, 1, 8'h20, 8'h24, 5'h01, 5'h0A, 0, 1, 0, 0, 0);
        step(1, 1, 8'h28, 8'h2C, 5'h02, 5'h03, 1, 1, 0, 0, 0);
        step(1, 0, 8'h30, 8'h00, 5'h04, 5'h00, 0, 0, 0, 0, 0);
        resolve(1, 0);
        resolve(2, 0); resolve(3, 0); resolve(4, 1);
        drain();

        // Fill with single allocates, then a 2-wide request at count 7, then free one slot.
        for (int i = 0; i < 8; i++) step(1, 0, 8'(8'h40 + i), 8'h00, 5'(i), 5'h00, i[0], 0, 0, 0, 0);
        step(1, 1, 8'h60, 8'h64, 5'h11, 5'h12, 1, 1, 0, 0, 0);
        resolve(mq[0].tag, mq[0].pred);
        idle(); idle();
        drain();

        // Wrap tags repeatedly with one branch in flight.
        for (int i = 0; i < 20; i++) begin
            step(1, 0, 8'(8'h80 + i), 8'h00, 5'(i), 5'h00, i[1], 0, 0, 0, 0);
            resolve(mq[mq.size() - 1].tag, mq[mq.size() - 1].pred);
            idle();
        end
        drain();

        // Mispredicting head resolve in the same cycle as a slot-2-only allocate.
        step(1, 1, 8'hA0, 8'hA4, 5'h05, 5'h06, 0, 1, 0, 0, 0);
        step(0, 1, 8'h00, 8'hA8, 5'h00, 5'h07, 0, 0, 1, mq[0].tag, 1);
        idle(); idle(); idle();
        drain();

        // Randomized traffic.
        for (int k = 0; k < 400; k++) begin
            bit v1  = ($urandom_range(0, 2) != 0);
            bit v2  = ($urandom_range(0, 2) == 0);
            bit rv  = ($urandom_range(0, 3) != 0);
            int rt  = int'($urandom_range(0, 7));
            bit rtk = 1'($urandom_range(0, 1));
            if (mq.size() > 0 && $urandom_range(0, 3) != 0) begin
                int j = int'($urandom_range(0, mq.size() - 1));
                rt  = mq[j].tag;
                rtk = ($urandom_range(0, 5) == 0) ? !mq[j].pred : mq[j].pred;
            end
            step(v1, v2, 8'($urandom), 8'($urandom), 5'($urandom), 5'($urandom),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rv, rt, rtk);
        end
        drain();

        // Reset while four entries are pending with a retire and a mispredict both due.
        do_reset("reset3");
        step(1, 1, 8'hC0, 8'hC4, 5'h01, 5'h02, 1, 0, 0, 0, 0);
        step(1, 1, 8'hC8, 8'hCC, 5'h03, 5'h04, 1, 1, 0, 0, 0);
        resolve(0, 1);
        drive(0, 0, 8'h00, 8'h00, 5'h00, 5'h00, 0, 0, 1, 2, 0);
        #2;
        rst = 1'b0;
        #1;
        chk_reset_outs("midrst");
        clear_model();
        @(negedge clk);
        drive(0, 0, 8'h00, 8'h00, 5'h00, 5'h00, 0, 0, 0, 0, 0);
        rst = 1'b1;
        repeat (4) idle();

        chk("upd_q_left", 32'(upd_q.size()), 32'd0);
        chk("mp_q_left", 32'(mp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
